dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 117 +++++++++++
 tb/tb_dcache_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Data-cache controller: hits answer in the request cycle, misses stall for MISS_WAIT cycles then fill.
// stall and resp_valid are combinational; the pipeline holds its request stable while stall is high.
module dcache_ctrl #(
  parameter int unsigned MISS_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        c_write,
  output logic        c_copy,
  output logic        c_reset,
  output logic [15:0] c_address,
  output logic [31:0] c_write_data,
  input  logic [31:0] c_read_data,
  input  logic        c_hit,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic [1:0] {IDLE, WAIT, FILL, FLUSH} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(MISS_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] miss_addr_q, miss_addr_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        c_write_raw, c_copy_raw;
  logic        load_req;
  logic        unused_addr_bits;

  assign load_req         = req_valid & ~req_write;
  assign rdata            = c_read_data;
  assign c_write_data     = req_wdata;
  assign hit_count        = hit_count_q;
  assign miss_count       = miss_count_q;
  // Strobes are suppressed while reset is held so a stale state cannot touch the array.
  assign c_write          = c_write_raw & ~reset;
  assign c_copy           = c_copy_raw & ~reset;
  assign unused_addr_bits = ^{req_addr[31:18], req_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_addr_d  = miss_addr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    stall        = 1'b0;
    resp_valid   = 1'b0;
    c_write_raw  = 1'b0;
    c_copy_raw   = 1'b0;
    c_reset      = reset;
    c_address    = req_addr[17:2];
    case (state_q)
      IDLE: begin
        if (flush) begin
          stall   = 1'b1;
          state_d = FLUSH;
        end else if (req_valid && req_write) begin
          c_write_raw = 1'b1;
        end else if (load_req && c_hit) begin
          resp_valid = 1'b1;
          if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
        end else if (load_req) begin
          stall       = 1'b1;
          miss_addr_d = req_addr[17:2];
          cnt_d       = WAIT_LOAD;
          state_d     = WAIT;
          if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
        end
      end
      WAIT: begin
        stall     = 1'b1;
        c_address = miss_addr_q;
        if (cnt_q == 4'd0) state_d = FILL;
        else               cnt_d   = cnt_q - 4'd1;
      end
      FILL: begin
        c_copy_raw = 1'b1;
        resp_valid = 1'b1;
        c_address  = miss_addr_q;
        state_d    = IDLE;
      end
      FLUSH: begin
        stall   = 1'b1;
        c_reset = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      miss_addr_q  <= 16'd0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_addr_q  <= miss_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a 256-line direct-mapped cache plus word memory surround the controller,
// and a transaction-level model predicts stall length, load data, strobes and statistics per request.
module tb_dcache_ctrl;

  localparam int MISS_WAIT = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic [31:0] rdata;
  logic        resp_valid;
  logic        c_write;
  logic        c_copy;
  logic        c_reset;
  logic [15:0] c_address;
  logic [31:0] c_write_data;
  logic [31:0] c_read_data;
  logic        c_hit;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_tests = 0;
  int n_fail  = 0;

  dcache_ctrl #(.MISS_WAIT(MISS_WAIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .stall        (stall),
    .rdata        (rdata),
    .resp_valid   (resp_valid),
    .c_write      (c_write),
    .c_copy       (c_copy),
    .c_reset      (c_reset),
    .c_address    (c_address),
    .c_write_data (c_write_data),
    .c_read_data  (c_read_data),
    .c_hit        (c_hit),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input logic [15:0] w);
    return {w ^ 16'hA5C3, ~w};
  endfunction

  // Environment: the cache array and backing memory, driven only by the controller's strobes.
  logic [31:0] env_mem [65536];
  logic [31:0] env_dat [256];
  logic [7:0]  env_tag [256];
  logic        env_vld [256];

  always_comb begin
    c_hit       = env_vld[c_address[7:0]] && (env_tag[c_address[7:0]] == c_address[15:8]);
    c_read_data = c_copy ? env_mem[c_address] : env_dat[c_address[7:0]];
  end

  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 65536; i++) env_mem[i] <= mem_init(16'(i));
    if (c_reset === 1'b1) begin
      for (int i = 0; i < 256; i++) env_vld[i] <= 1'b0;
    end else if (c_write === 1'b1) begin
      env_mem[c_address]      <= c_write_data;
      env_dat[c_address[7:0]] <= c_write_data;
      env_tag[c_address[7:0]] <= c_address[15:8];
      env_vld[c_address[7:0]] <= 1'b1;
    end else if (c_copy === 1'b1) begin
      env_dat[c_address[7:0]] <= env_mem[c_address];
      env_tag[c_address[7:0]] <= c_address[15:8];
      env_vld[c_address[7:0]] <= 1'b1;
    end
  end

  // Reference model: what the cache should hold and what each request should cost.
  logic [31:0] ref_mem [65536];
  logic [7:0]  ref_tag [256];
  bit          ref_vld [256];
  int          ref_hits;
  int          ref_misses;

  task automatic reset_model();
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem_init(16'(i));
    for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One pipeline request (optionally with flush), held until stall drops, then one idle cycle.
  task automatic do_op(input bit fl, input bit vld, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, output int stalls, output logic [31:0] dat);
    logic [15:0] w;
    logic [7:0]  idx;
    logic [15:0] addr_at_done;
    bit          hit, is_load, is_store, miss;
    int          exp_stalls, resps, creset_n, copy_n, write_n, ovl;
    bit          done;
    logic [31:0] exp_dat;

    w        = addr[17:2];
    idx      = w[7:0];
    is_load  = vld && !wr;
    is_store = vld && wr;
    if (fl) for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;
    exp_stalls = fl ? 2 : 0;
    hit        = ref_vld[idx] && (ref_tag[idx] == w[15:8]);
    miss       = is_load && !hit;
    exp_dat    = 32'd0;
    if (is_load) begin
      exp_dat = ref_mem[w];
      if (hit) ref_hits++;
      else begin
        ref_misses++;
        exp_stalls += 1 + MISS_WAIT;
      end
    end else if (is_store) begin
      ref_mem[w] = wd;
    end
    if (vld) begin
      ref_vld[idx] = 1'b1;
      ref_tag[idx] = w[15:8];
    end

    @(negedge clk);
    req_valid = vld;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    flush     = fl;
    stalls = 0; resps = 0; creset_n = 0; copy_n = 0; write_n = 0; ovl = 0;
    done = 1'b0; dat = 32'd0; addr_at_done = 16'd0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (resp_valid) begin
        resps++;
        dat = rdata;
      end
      if (c_reset) creset_n++;
      if (c_copy) copy_n++;
      if (c_write) write_n++;
      if (c_write && c_copy) ovl++;
      if (stall) begin
        stalls++;
        @(negedge clk);
        flush = 1'b0;
      end else begin
        done         = 1'b1;
        addr_at_done = c_address;
      end
    end
    check("op_done", 32'(done), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    #1;
    check("stall_cycles", stalls, exp_stalls);
    check("resp_count", resps, is_load ? 1 : 0);
    if (is_load) check("load_data", dat, exp_dat);
    if (vld) check("c_address", 32'(addr_at_done), 32'(w));
    check("c_reset_pulses", creset_n, fl ? 1 : 0);
    check("c_copy_pulses", copy_n, miss ? 1 : 0);
    check("c_write_pulses", write_n, is_store ? 1 : 0);
    check("write_copy_overlap", ovl, 0);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_resp", 32'(resp_valid), 32'd0);
    check("idle_strobes", 32'({c_write, c_copy, c_reset}), 32'd0);
    check("hit_count", hit_count, ref_hits);
    check("miss_count", miss_count, ref_misses);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int          st;
    logic [31:0] d, r;
    bit          fl, vld, wr;

    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h44;
    req_wdata = 32'hDEAD_BEEF;
    flush     = 1'b0;
    reset_model();

    // A store held across reset must not reach the array.
    @(negedge clk); #1;
    check("rst_c_reset", 32'(c_reset), 32'd1);
    check("rst_c_write", 32'(c_write), 32'd0);
    check("rst_c_copy", 32'(c_copy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_resp", 32'(resp_valid), 32'd0);
    check("post_rst_c_reset", 32'(c_reset), 32'd0);
    check("post_rst_hits", hit_count, 32'd0);
    check("post_rst_misses", miss_count, 32'd0);

    // Cold load, then the same address hits.
    do_op(1'b0, 1'b1, 1'b0, 32'h40, 32'd0, st, d);
    check("cold_stall", st, 4);
    check("cold_data", d, mem_init(16'h0010));
    check("cold_misses", miss_count, 32'd1);
    do_op(1'b0, 1'b1, 1'b0, 32'h40, 32'd0, st, d);
    check("warm_stall", st, 0);
    check("warm_hits", hit_count, 32'd1);

    // Store then load the same word.
    do_op(1'b0, 1'b1, 1'b1, 32'h44, 32'h1234_5678, st, d);
    check("store_stall", st, 0);
    do_op(1'b0, 1'b1, 1'b0, 32'h44, 32'd0, st, d);
    check("st_ld_stall", st, 0);
    check("st_ld_data", d, 32'h1234_5678);

    // Two tags on the same line evict each other.
    do_op(1'b0, 1'b1, 1'b0, 32'h400, 32'd0, st, d);
    check("conflict_a_stall", st, 4);
    do_op(1'b0, 1'b1, 1'b0, 32'h000, 32'd0, st, d);
    check("conflict_b_stall", st, 4);
    check("conflict_b_data", d, mem_init(16'h0000));
    check("conflict_misses", miss_count, 32'd3);

    // Flush with a load to a cached word pending: the load now misses.
    do_op(1'b1, 1'b1, 1'b0, 32'h40, 32'd0, st, d);
    check("flush_ld_stall", st, 2 + 1 + MISS_WAIT);
    check("flush_ld_misses", miss_count, 32'd4);

    // Reset during the second WAIT cycle of a miss.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h8000;
    #1;
    check("rw_miss_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    check("rw_wait1_stall", 32'(stall), 32'd1);
    check("rw_wait1_copy", 32'(c_copy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rw_c_reset", 32'(c_reset), 32'd1);
    check("rw_copy", 32'(c_copy), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    reset_model();
    #1;
    check("rw_idle_stall", 32'(stall), 32'd0);
    check("rw_idle_resp", 32'(resp_valid), 32'd0);
    check("rw_idle_copy", 32'(c_copy), 32'd0);
    check("rw_hits", hit_count, 32'd0);
    check("rw_misses", miss_count, 32'd0);
    @(negedge clk); #1;
    check("rw_after_copy", 32'(c_copy), 32'd0);
    check("rw_after_stall", 32'(stall), 32'd0);

    // Random traffic over a small footprint so hits, conflicts and flushes all occur.
    for (int n = 0; n < 300; n++) begin
      r   = $urandom();
      fl  = ($urandom_range(0, 11) == 0);
      vld = ($urandom_range(0, 7) != 0);
      wr  = ($urandom_range(0, 2) == 0);
      do_op(fl, vld, wr,
            {r[31:18], 8'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), r[1:0]},
            $urandom(), st, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
